// File: rtl/mesh_input_router.sv
// ---------------------------------------------------------------------------
// mesh_input_router
//
// Per-input-port routing stage for the 2-D mesh NoC. Each request packet is
// accepted on a valid/ready handshake. Its output direction is resolved at
// enqueue with dimension-ordered routing, either row-first or column-first.
// The packet is then buffered in a DEPTH-entry FIFO and the head entry is
// presented to the crossbar. A packet with both readIn and writeIn set is
// malformed: it is discarded and counted.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   localRouterAddress         this router's {row, column}
//   routeMode                  0 = row-first, 1 = column-first (per packet)
//   in_valid / in_ready        upstream handshake (in_ready = !full)
//   destinationAddressIn       {row, column, bank} of the request
//   requesterAddressIn         originating router {row, column}
//   readIn, writeIn            request type
//   out_valid / out_ready      crossbar handshake for the head entry
//   outputPortSelect           one-hot {W, E, S, N, local}
//   memRead, memWrite          head request type, only for local routes
//   destinationAddressOut      head destination
//   requesterAddressOut        head requester
//   occupancy                  number of buffered entries
//   dropPulse                  one cycle per discarded malformed packet
//   dropCount                  saturating discard counter
// ---------------------------------------------------------------------------
module mesh_input_router #(
    parameter  int ROW_W  = 2,
    parameter  int COL_W  = 2,
    parameter  int BANK_W = 4,
    parameter  int DEPTH  = 4,
    localparam int NET_W  = ROW_W + COL_W,
    localparam int OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NET_W-1:0]        localRouterAddress,
    input  logic                    routeMode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NET_W+BANK_W-1:0] destinationAddressIn,
    input  logic [NET_W-1:0]        requesterAddressIn,
    input  logic                    readIn,
    input  logic                    writeIn,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              outputPortSelect,
    output logic                    memRead,
    output logic                    memWrite,
    output logic [NET_W+BANK_W-1:0] destinationAddressOut,
    output logic [NET_W-1:0]        requesterAddressOut,
    output logic [OCC_W-1:0]        occupancy,
    output logic                    dropPulse,
    output logic [7:0]              dropCount
);

    localparam int ADDR_W = NET_W + BANK_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = OCC_W;

    localparam logic [4:0] PORT_LOCAL = 5'b00001;
    localparam logic [4:0] PORT_NORTH = 5'b00010;
    localparam logic [4:0] PORT_SOUTH = 5'b00100;
    localparam logic [4:0] PORT_EAST  = 5'b01000;
    localparam logic [4:0] PORT_WEST  = 5'b10000;

    // FIFO storage; not reset because out_valid masks every head output
    // that matters while the FIFO is empty.
    logic [4:0]        route_mem_q [DEPTH];
    logic              rd_mem_q    [DEPTH];
    logic              wr_mem_q    [DEPTH];
    logic [ADDR_W-1:0] dest_mem_q  [DEPTH];
    logic [NET_W-1:0]  req_mem_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic              full;
    logic              empty;
    logic              handshake;
    logic              accept;
    logic              malformed;
    logic              dequeue;

    logic [ROW_W-1:0]  dst_row, loc_row;
    logic [COL_W-1:0]  dst_col, loc_col;
    logic [4:0]        route_new;
    logic              mem_rd_new;
    logic              mem_wr_new;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign handshake = in_valid && !full;
    assign accept    = handshake && (readIn ^ writeIn);
    assign malformed = handshake && readIn && writeIn;
    assign dequeue   = !empty && out_ready;

    assign dst_row = destinationAddressIn[ADDR_W-1 -: ROW_W];
    assign dst_col = destinationAddressIn[BANK_W +: COL_W];
    assign loc_row = localRouterAddress[NET_W-1 -: ROW_W];
    assign loc_col = localRouterAddress[COL_W-1:0];

    // Dimension-ordered route. The route falls through to local only when
    // both coordinates match.
    always_comb begin
        route_new = PORT_LOCAL;
        if (!routeMode) begin
            if (dst_row > loc_row)      route_new = PORT_SOUTH;
            else if (dst_row < loc_row) route_new = PORT_NORTH;
            else if (dst_col > loc_col) route_new = PORT_EAST;
            else if (dst_col < loc_col) route_new = PORT_WEST;
        end else begin
            if (dst_col > loc_col)      route_new = PORT_EAST;
            else if (dst_col < loc_col) route_new = PORT_WEST;
            else if (dst_row > loc_row) route_new = PORT_SOUTH;
            else if (dst_row < loc_row) route_new = PORT_NORTH;
        end
        mem_rd_new = (route_new == PORT_LOCAL) && readIn;
        mem_wr_new = (route_new == PORT_LOCAL) && writeIn;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_pulse_d = malformed;
        drop_cnt_d   = drop_cnt_q;

        // Pointer width equals log2(DEPTH), so the increment wraps on its own.
        if (accept)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (dequeue) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (accept && !dequeue)      count_d = count_q + CNT_W'(1);
        else if (!accept && dequeue) count_d = count_q - CNT_W'(1);

        if (malformed && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // A write in the reset cycle is harmless: the write pointer returns to 0
    // and the entry is never made visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            route_mem_q[wr_ptr_q] <= route_new;
            rd_mem_q[wr_ptr_q]    <= mem_rd_new;
            wr_mem_q[wr_ptr_q]    <= mem_wr_new;
            dest_mem_q[wr_ptr_q]  <= destinationAddressIn;
            req_mem_q[wr_ptr_q]   <= requesterAddressIn;
        end
    end

    assign in_ready              = !full;
    assign out_valid             = !empty;
    assign occupancy             = count_q;
    assign outputPortSelect      = empty ? 5'b00000 : route_mem_q[rd_ptr_q];
    assign memRead               = !empty && rd_mem_q[rd_ptr_q];
    assign memWrite              = !empty && wr_mem_q[rd_ptr_q];
    assign destinationAddressOut = dest_mem_q[rd_ptr_q];
    assign requesterAddressOut   = req_mem_q[rd_ptr_q];
    assign dropPulse             = drop_pulse_q;
    assign dropCount             = drop_cnt_q;

endmodule

// File: doc/mesh_input_router.md
# mesh_input_router

Parametrised per-input-port routing stage for the 2-D mesh network-on-chip. It accepts request packets over a valid/ready handshake and computes the output direction at enqueue using dimension-ordered routing, selectable row-first or column-first. Packets are buffered in a DEPTH-entry FIFO and presented, with the computed route, to the router crossbar. It sits between each external router input link and the crossbar/local cache-bank port, and adds input buffering, back-pressure, runtime routing order and malformed-request filtering.

## Interface
- ROW_W, 2, row field width of the network address
- COL_W, 2, column field width of the network address
- BANK_W, 4, cache-bank field width appended below the network address
- DEPTH, 4, FIFO entries; power of two, ≥2
- NET_W (local), ROW_W+COL_W; address layout is {row, column}, row in the upper bits
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- localRouterAddress  in  NET_W  this router's {row, column}
- routeMode  in  1  0 = row-first (north/south before east/west), 1 = column-first; sampled per packet at enqueue
- in_valid  in  1  upstream packet present
- in_ready  out  1  FIFO can accept; equals !full
- destinationAddressIn  in  NET_W+BANK_W  {network address, bank address}
- requesterAddressIn  in  NET_W  originating router
- readIn, writeIn  in  1 each  request type
- out_valid  out  1  head entry present; equals count≠0
- out_ready  in  1  crossbar accepts head this cycle
- outputPortSelect  out  5  one-hot route: bit0 local, bit1 north, bit2 south, bit3 east, bit4 west
- memRead, memWrite  out  1 each  head request type; nonzero only when the route is local
- destinationAddressOut  out  NET_W+BANK_W  head destination, passed through
- requesterAddressOut  out  NET_W  head requester, passed through
- occupancy  out  log2(DEPTH)+1  current entry count
- dropPulse  out  1  one-cycle pulse when a malformed packet is discarded
- dropCount  out  8  saturating count of discarded packets

## Operation
- Accept: in_valid && in_ready && (readIn ^ writeIn). Write an entry at wr_ptr. The entry holds route, memRead, memWrite, destination and requester.
- Malformed: in_valid && in_ready && readIn && writeIn. Do not enqueue. Assert dropPulse next cycle. Increment dropCount, saturating at 255.
- in_valid with neither readIn nor writeIn is ignored; no enqueue, no drop.
- Route computation (dr/dc = destination row/column, lr/lc = local row/column):
  - Equal addresses → local. memRead = readIn, memWrite = writeIn.
  - routeMode 0: dr>lr south; dr<lr north; otherwise dc>lc east, dc<lc west.
  - routeMode 1: dc>lc east; dc<lc west; otherwise dr>lr south, dr<lr north.
  - Non-local routes store memRead = memWrite = 0. Comparisons are unsigned.
- Dequeue: out_valid && out_ready; advance rd_ptr.
- Pointers wrap modulo DEPTH.
- Occupancy:
  - count +1 on accept only.
  - count −1 on dequeue only.
  - Unchanged on simultaneous accept and dequeue.
- When out_valid=0: outputPortSelect, memRead and memWrite are forced to 0; the address outputs are don't-care.
- The route is frozen at enqueue. Later changes to localRouterAddress or routeMode do not alter buffered entries.

## Timing
- Reset values: pointers 0, count 0, in_ready 1, out_valid 0, outputPortSelect 0, memRead 0, memWrite 0, dropPulse 0, dropCount 0, occupancy 0.
- Reset mid-operation flushes all entries in one cycle. Any handshake in the reset cycle is ignored.
- Latency: a packet accepted at edge N is visible with out_valid=1 after edge N (cycle N+1), if it reaches the head.
- Throughput: one accept and one dequeue per cycle.
- Full (count=DEPTH): in_ready=0 even if out_ready=1. There is no same-cycle pass-through when full.
- Empty: out_valid=0. An accept into an empty FIFO appears the next cycle; there is no combinational bypass.
- Head outputs are driven from storage and are stable while out_valid && !out_ready.
- dropPulse is high exactly one cycle per malformed packet. Back-to-back malformed packets give a continuous high and count each packet.

## Test plan
- Local hit: local=4'b0101, dest={4'b0101,4'h3}, readIn=1 → next cycle out_valid=1, outputPortSelect=5'b00001, memRead=1, memWrite=0.
- Routing order: local=4'b0101, dest net=4'b1010. With routeMode=0 → 5'b00100 (south). With routeMode=1 → 5'b01000 (east), memRead=memWrite=0. Dest net=4'b0100 → west in both modes.
- Fill/back-pressure (DEPTH=4): 4 accepts with out_ready=0 → in_ready=0 and occupancy=4. Then pop 1 → in_ready=1. Order is preserved over 8 packets including pointer wrap.
- Simultaneous push/pop at occupancy 2 for 10 cycles → occupancy stays 2; outputs match input order.
- Malformed: readIn=writeIn=1 → no enqueue, dropPulse for 1 cycle, dropCount=1. Drive 300 malformed packets → dropCount=255.
- Reset with 3 entries buffered and in_valid=1 → next cycle occupancy=0, out_valid=0, in_ready=1, dropCount=0.
